ece571_alu_arbiter: RTL and testbench
=====================================

Name: ece571_alu_arbiter

Overview:
Shares one ece571_alu instance between NREQ requesters using round-robin arbitration and valid/ready handshakes. It accepts at most one operation per cycle and evaluates it on the combinational ALU. The result is captured in a single registered response stage that is tagged with the requester index. It sits between the issue/execute clients of the CPU and the shared ALU datapath.

Parameters:
N, 32, operand and result width passed to ece571_alu
NREQ, 4, number of requesters (2..16)
IDW, $clog2(NREQ), width of the requester-index tag (localparam, not overridable)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous reset, active-low
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept (one-hot or zero)
req_opcode  in  NREQ x opcode_t  per-requester ALU opcode (packed array)
req_a  in  NREQ x N  per-requester operand a (packed array)
req_b  in  NREQ x N  per-requester operand b (packed array)
rsp_valid  out  1  response register holds a result
rsp_ready  in  1  consumer accepts the response
rsp_id  out  IDW  index of the requester that owns the response
rsp_result  out  N  ALU result

Behaviour:
- Reset, async on rst_n low: rsp_valid=0, rsp_id=0, rsp_result=0, rr_ptr=0. req_ready is 0 while rst_n is low.
- accept_en = !rsp_valid || rsp_ready. The response stage is free or draining in the same cycle.
- Arbitration is combinational. Search req_valid starting at rr_ptr, ascending, wrapping at NREQ-1 to 0. The first set bit wins.
- req_ready[g] = accept_en && req_valid[g] for winner g. All other req_ready bits are 0, and all are 0 when no request is valid.
- req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Transfer occurs when req_valid[g] && req_ready[g]. On that clock edge: rsp_result <= alu(req_opcode[g], req_a[g], req_b[g]), rsp_id <= g, rsp_valid <= 1, rr_ptr <= (g+1) mod NREQ.
- If no transfer occurs: rr_ptr holds. If rsp_valid && rsp_ready, then rsp_valid <= 0. Otherwise the response registers hold.
- Latency is 1 cycle from transfer to rsp_valid. Throughput is 1 op/cycle when rsp_ready is held high, with a simultaneous drain and refill in the same cycle.
- Backpressure: while rsp_valid && !rsp_ready, all req_ready=0, rsp_* stay stable and rr_ptr holds.
- Requester protocol: once valid is asserted, opcode, a and b stay stable and valid stays high until ready.
- ALU arithmetic is modulo 2^N; carries and borrows are discarded.
- Opcodes: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR. Any other opcode encoding produces result 0 and is still a normal transfer with a valid response.
- Fairness: a continuously asserted requester is granted within NREQ transfers.
- Reset mid-operation: a pending response is discarded, rr_ptr returns to 0, and no grant is issued until rst_n is high.

Decomposition:
- ece571_cpu_pkg: reuse opcode_t. Add localparam NREQ_DEFAULT=4.
- Sub-module ece571_rr_arbiter (params NREQ). Inputs: clk, rst_n, req, en. Outputs: one-hot gnt, gnt_idx. It owns rr_ptr, which advances only when en && |req.
- The top level instantiates ece571_rr_arbiter and ece571_alu and holds the operand mux and response register.

Test Plan:
- Reset with req_valid=4'b1111 and rst_n low: req_ready=0, rsp_valid=0, rsp_result=0. After release, req 0 is granted first.
- Single request: req 2, OP_ADD, a=32'hFFFF_FFFF, b=1, rsp_ready=1. Next cycle: rsp_valid=1, rsp_id=2, rsp_result=0 (wrap).
- Full contention: all four valid and held, rsp_ready=1. Grant order is 0,1,2,3,0. Each rsp_id matches one cycle later. Per-requester results are correct for SUB 5-7=32'hFFFF_FFFE, AND, OR and XOR.
- Backpressure: rsp_ready=0 for 3 cycles with reqs pending. Expect req_ready=0, rsp_* stable, and rr_ptr unchanged. When rsp_ready rises, drain and refill happen in the same cycle.
- Illegal opcode encoding from req 1 with a=b=32'h1234: rsp_valid=1, rsp_id=1, rsp_result=0.
- Reset asserted while rsp_valid=1: rsp_valid drops immediately, asynchronously. The next grant after release starts from index 0.

Source files
------------

// File: rtl/ece571_cpu_pkg.sv
// Shared CPU definitions: ALU opcode encoding and default requester count.
package ece571_cpu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4
  } opcode_t;

  localparam int NREQ_DEFAULT = 4;

endpackage

// File: rtl/ece571_alu.sv
// Combinational N-bit ALU; arithmetic wraps modulo 2^N, unknown opcodes yield 0.
module ece571_alu
  import ece571_cpu_pkg::*;
#(
  parameter int N = 32
) (
  input  opcode_t        opcode,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [N-1:0]   result
);

  always_comb begin
    result = '0;
    case (opcode)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/ece571_rr_arbiter.sv
// Round-robin arbiter: searches upward from rr_ptr with wrap, pointer moves past
// the winner only when a grant is actually taken (en && |req).
module ece571_rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] rr_ptr_next;
  logic           found;
  int             k;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(rr_ptr) + i) % NREQ;
      if (!found && req[k]) begin
        gnt[k]  = 1'b1;
        gnt_idx = k[IDW-1:0];
        found   = 1'b1;
      end
    end
  end

  // Explicit wrap keeps non-power-of-two NREQ correct.
  assign rr_ptr_next = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (en && |req) begin
      rr_ptr <= rr_ptr_next;
    end
  end

endmodule

// File: rtl/ece571_alu_arbiter.sv
// Shares one ALU among NREQ valid/ready requesters; one op per cycle, result held
// in a single tagged response register that can drain and refill in the same cycle.
module ece571_alu_arbiter
  import ece571_cpu_pkg::*;
#(
  parameter  int N    = 32,
  parameter  int NREQ = NREQ_DEFAULT,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  opcode_t [NREQ-1:0]       req_opcode,
  input  logic [NREQ-1:0][N-1:0]   req_a,
  input  logic [NREQ-1:0][N-1:0]   req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [N-1:0]             rsp_result
);

  logic            accept_en;
  logic            arb_en;
  logic            xfer;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  opcode_t         sel_opcode;
  logic [N-1:0]    sel_a;
  logic [N-1:0]    sel_b;
  logic [N-1:0]    alu_result;

  logic            rsp_valid_reg;
  logic [IDW-1:0]  rsp_id_reg;
  logic [N-1:0]    rsp_result_reg;

  // rst_n gating: the async clear empties the response stage, which would
  // otherwise open accept_en while reset is still held.
  assign accept_en = !rsp_valid_reg || rsp_ready;
  assign arb_en    = rst_n && accept_en;
  assign req_ready = arb_en ? gnt : '0;
  assign xfer      = arb_en && |req_valid;

  ece571_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign sel_opcode = req_opcode[gnt_idx];
  assign sel_a      = req_a[gnt_idx];
  assign sel_b      = req_b[gnt_idx];

  ece571_alu #(
    .N (N)
  ) u_alu (
    .opcode (sel_opcode),
    .a      (sel_a),
    .b      (sel_b),
    .result (alu_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= '0;
      rsp_result_reg <= '0;
    end else if (xfer) begin
      rsp_valid_reg  <= 1'b1;
      rsp_id_reg     <= gnt_idx;
      rsp_result_reg <= alu_result;
    end else if (rsp_ready) begin
      rsp_valid_reg  <= 1'b0;
    end
  end

  assign rsp_valid  = rsp_valid_reg;
  assign rsp_id     = rsp_id_reg;
  assign rsp_result = rsp_result_reg;

endmodule

// File: tb/tb_ece571_alu_arbiter.sv
// Directed bench for ece571_alu_arbiter: inputs change and outputs are sampled
// on the falling edge, away from the rising active edge.
module tb_ece571_alu_arbiter;
  import ece571_cpu_pkg::*;

  logic                clk;
  logic                rst_n;
  logic [3:0]          req_valid;
  logic [3:0]          req_ready;
  opcode_t [3:0]       req_opcode;
  logic [3:0][31:0]    req_a;
  logic [3:0][31:0]    req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [1:0]          rsp_id;
  logic [31:0]         rsp_result;

  int checks;
  int errors;
  logic [31:0] exp_res [4];

  ece571_alu_arbiter #(
    .N    (32),
    .NREQ (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready: got %b expected %b", req_ready, 4'b0000);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", rsp_valid);
    end
    checks++;
    if (rsp_result !== 32'h0 || rsp_id !== 2'd0) begin
      errors++; $display("FAIL reset_rsp: got id %0d result %h expected id 0 result 0", rsp_id, rsp_result);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL reset_first_grant: got %b expected %b", req_ready, 4'b0001);
    end
    $display("reset released: req_ready=%b", req_ready);
    req_valid = 4'b0000;
  endtask

  task automatic test_single();
    @(negedge clk);
    req_valid     = 4'b0100;
    req_opcode[2] = OP_ADD;
    req_a[2]      = 32'hFFFF_FFFF;
    req_b[2]      = 32'h0000_0001;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_ready: got %b expected %b", req_ready, 4'b0100);
    end
    @(posedge clk);
    @(negedge clk);
    $display("single: valid=%b id=%0d result=%h", rsp_valid, rsp_id, rsp_result);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 32'h0) begin
      errors++; $display("FAIL single_rsp: got v%b id %0d %h expected v1 id 2 00000000", rsp_valid, rsp_id, rsp_result);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_contention();
    logic [3:0] exp_gnt;
    int g;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req_opcode[0] = OP_XOR; req_a[0] = 32'hA5A5_A5A5; req_b[0] = 32'hFFFF_0000;
    req_opcode[1] = OP_SUB; req_a[1] = 32'd5;         req_b[1] = 32'd7;
    req_opcode[2] = OP_AND; req_a[2] = 32'hF0F0_1234; req_b[2] = 32'h0FF0_FF00;
    req_opcode[3] = OP_OR;  req_a[3] = 32'h1200_0034; req_b[3] = 32'h0000_5600;
    exp_res[0] = 32'h5A5A_A5A5;
    exp_res[1] = 32'hFFFF_FFFE;
    exp_res[2] = 32'h00F0_1200;
    exp_res[3] = 32'h1200_5634;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      g = i % 4;
      exp_gnt = 4'b0001 << g;
      checks++;
      if (req_ready !== exp_gnt) begin
        errors++; $display("FAIL contention_grant%0d: got %b expected %b", i, req_ready, exp_gnt);
      end
      @(posedge clk);
      @(negedge clk);
      $display("contention %0d: id=%0d result=%h", i, rsp_id, rsp_result);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== g[1:0] || rsp_result !== exp_res[g]) begin
        errors++; $display("FAIL contention_rsp%0d: got v%b id %0d %h expected v1 id %0d %h",
                           i, rsp_valid, rsp_id, rsp_result, g, exp_res[g]);
      end
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL bp_ready_initial: got %b expected 0000", req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      $display("backpressure %0d: ready=%b id=%0d result=%h", i, req_ready, rsp_id, rsp_result);
      checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== exp_res[0]) begin
        errors++; $display("FAIL bp_hold%0d: got ready %b v%b id %0d %h expected 0000 v1 id 0 %h",
                           i, req_ready, rsp_valid, rsp_id, rsp_result, exp_res[0]);
      end
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL bp_resume_grant: got %b expected 0010", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    $display("refill: id=%0d result=%h", rsp_id, rsp_result);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== exp_res[1]) begin
      errors++; $display("FAIL bp_refill: got v%b id %0d %h expected v1 id 1 %h",
                         rsp_valid, rsp_id, rsp_result, exp_res[1]);
    end
    req_valid = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: got v%b expected v0", rsp_valid);
    end
  endtask

  task automatic test_illegal();
    logic [2:0] bad_op;
    bad_op        = 3'b111;
    req_valid     = 4'b0010;
    req_opcode[1] = opcode_t'(bad_op);
    req_a[1]      = 32'h1234;
    req_b[1]      = 32'h1234;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL illegal_ready: got %b expected 0010", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    $display("illegal: valid=%b id=%0d result=%h", rsp_valid, rsp_id, rsp_result);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 32'h0) begin
      errors++; $display("FAIL illegal_rsp: got v%b id %0d %h expected v1 id 1 00000000",
                         rsp_valid, rsp_id, rsp_result);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    @(negedge clk);
    req_valid     = 4'b0100;
    req_opcode[2] = OP_ADD;
    req_a[2]      = 32'd1;
    req_b[2]      = 32'd1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 32'd2) begin
      errors++; $display("FAIL midrst_pre: got v%b id %0d %h expected v1 id 2 00000002",
                         rsp_valid, rsp_id, rsp_result);
    end
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    $display("mid reset: valid=%b ready=%b", rsp_valid, req_ready);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'h0 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL midrst_async: got v%b %h ready %b expected v0 00000000 ready 0000",
                         rsp_valid, rsp_result, req_ready);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL midrst_first_grant: got %b expected 0001", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    $display("post reset: id=%0d result=%h", rsp_id, rsp_result);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== exp_res[0]) begin
      errors++; $display("FAIL midrst_rsp: got v%b id %0d %h expected v1 id 0 %h",
                         rsp_valid, rsp_id, rsp_result, exp_res[0]);
    end
    req_valid = 4'b0000;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
